// File: rtl/fp_mul_pkg.sv
// Shared definitions for the two-requester FP multiplier scheduler.
// Contents:
//   FP_W          operand/result width (fixed by the MUL datapath)
//   ID_W          requester index width
//   ST_*          FSM state codes, wrapped by the state_t enum
package fp_mul_pkg;

  localparam int FP_W = 32;
  localparam int ID_W = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

endpackage

// File: rtl/MUL.sv
// Combinational IEEE-754 single-precision multiplier shared by the scheduler.
// Round-to-nearest-even; subnormal inputs and underflowing results are
// flushed to signed zero; any NaN input yields the canonical quiet NaN.
// Ports:
//   in1, in2  operands
//   out       product
module MUL (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out
);

  logic        sign;
  logic [7:0]  ea, eb, exp_out;
  logic [23:0] ma, mb, frac_r;
  logic [47:0] prod;
  logic [22:0] frac;
  logic        guard, sticky, round_up;
  logic [9:0]  exp_pre, exp_sum;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    sign   = in1[31] ^ in2[31];
    ea     = in1[30:23];
    eb     = in2[30:23];
    ma     = {1'b1, in1[22:0]};
    mb     = {1'b1, in2[22:0]};
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (in1[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (in2[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (in1[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (in2[22:0] != 23'd0);

    prod    = {24'd0, ma} * {24'd0, mb};
    // Biased exponent sum before removing one bias; product in [1,4) needs
    // a one-bit normalisation when the top bit is set.
    exp_pre = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]};
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard && (sticky || frac[0]);
    frac_r   = {1'b0, frac} + {23'd0, round_up};
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    exp_sum  = exp_pre + {9'd0, frac_r[23]};
    exp_out  = 8'(exp_sum - 10'd127);

    out = {sign, 31'd0};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      out = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      out = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      out = {sign, 31'd0};
    end else if (exp_sum >= 10'd382) begin
      out = {sign, 8'hFF, 23'd0};
    end else if (exp_sum <= 10'd127) begin
      out = {sign, 31'd0};
    end else begin
      out = {sign, exp_out, frac_r[22:0]};
    end
  end

endmodule

// File: rtl/fp_mul_sched_arb.sv
// Two-way round-robin grant used by the scheduler.
// Ports:
//   req     per-requester request
//   ptr     requester that wins when both request
//   enable  grants are only issued while enabled
//   gnt     one-hot grant, or zero
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one combinational MUL between two requesters with round-robin
// arbitration. Operands and result are registered around MUL so its path is
// isolated from requester and consumer logic. One operation is in flight at
// a time: IDLE (accept) -> EXEC (multiply) -> RESP (hold until consumed).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      per-requester request handshake
//   req_a0, req_b0             requester 0 operands
//   req_a1, req_b1             requester 1 operands
//   rsp_valid / rsp_ready      shared response handshake
//   rsp_id, rsp_data           owner and product of the response
//   busy                       an operation is in flight
module fp_mul_sched #(
  parameter int FP_W  = 32,
  parameter int N_REQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [FP_W-1:0] req_a0,
  input  logic [FP_W-1:0] req_b0,
  input  logic [FP_W-1:0] req_a1,
  input  logic [FP_W-1:0] req_b1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [FP_W-1:0] rsp_data,
  output logic            busy
);
  import fp_mul_pkg::*;

  if (FP_W != fp_mul_pkg::FP_W || N_REQ != 2) begin : g_bad_param
    $error("fp_mul_sched supports only FP_W=32 and N_REQ=2");
  end

  state_t            state, next_state;
  logic              rr_ptr;
  logic [FP_W-1:0]   op_a, op_b, res, mul_out;
  logic [ID_W-1:0]   op_id;
  logic [1:0]        gnt;
  logic              accept;

  // Grants are suppressed during reset so req_ready reads 00 immediately.
  rr_arb2 u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable ((state == IDLE) && rst_n),
    .gnt    (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  MUL u_mul (
    .in1 (op_a),
    .in2 (op_b),
    .out (mul_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
      res    <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_a   <= gnt[1] ? req_a1 : req_a0;
        op_b   <= gnt[1] ? req_b1 : req_b0;
        op_id  <= gnt[1];
        rr_ptr <= ~gnt[1];
      end
      if (state == EXEC) begin
        res <= mul_out;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = res;
  assign rsp_id    = op_id;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_mul_sched.sv
// Self-checking bench for fp_mul_sched: a transaction-level reference model
// (one operation slot, round-robin priority bit, real-valued multiply)
// compared against the DUT every cycle, plus directed literal expectations.
module tb_fp_mul_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_data[$];
  logic        cap_id[$];

  // Reference model state: one slot, how long it has been occupied,
  // who owns it, what it must produce, and who wins a tie next.
  bit          m_pending = 1'b0;
  int          m_age = 0;
  bit          m_id = 1'b0;
  logic [31:0] m_data = '0;
  bit          m_prio = 1'b0;

  always #5 clk = ~clk;

  fp_mul_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Single-precision value as a real (normals and zero are enough here).
  function automatic real f2r(logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [1:0] model_grant(logic [1:0] v, bit prio);
    if (v == 2'b11) return prio ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic logic [31:0] cap_at(int idx);
    if (idx < cap_data.size()) return cap_data[idx];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic cap_id_at(int idx);
    if (idx < cap_id.size()) return cap_id[idx];
    return 1'bx;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic rdy);
    req_valid = v;
    req_a0    = a0;
    req_b0    = b0;
    req_a1    = a1;
    req_b1    = b1;
    rsp_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance the model on each clock edge using the inputs the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_age     = 0;
      m_prio    = 1'b0;
    end else if (!m_pending) begin
      logic [1:0] g;
      g = model_grant(req_valid, m_prio);
      if (g != 2'b00) begin
        m_pending = 1'b1;
        m_age     = 0;
        m_id      = g[1];
        m_data    = g[1] ? fp_model(req_a1, req_b1) : fp_model(req_a0, req_b0);
        m_prio    = ~g[1];
      end
    end else if (m_age >= 1 && rsp_ready) begin
      m_pending = 1'b0;
    end else begin
      m_age = 1;
    end
  end

  // Every-cycle comparison against the model, plus response capture.
  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic       exp_rsp;
    exp_ready = (!rst_n || m_pending) ? 2'b00 : model_grant(req_valid, m_prio);
    exp_rsp   = rst_n && m_pending && (m_age >= 1);
    checkOutput("cyc_req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    checkOutput("cyc_busy", {31'd0, busy}, {31'd0, rst_n && m_pending});
    checkOutput("cyc_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp});
    if (exp_rsp) begin
      checkOutput("cyc_rsp_data", rsp_data, m_data);
      checkOutput("cyc_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    end
    if (rsp_valid && rsp_ready) begin
      cap_data.push_back(rsp_data);
      cap_id.push_back(rsp_id);
    end
  end

  initial begin
    int base;

    // Model pins: hand-computed products.
    checkOutput("model_2x1", fp_model(32'h4000_0000, 32'h3F80_0000), 32'h4000_0000);
    checkOutput("model_5p25x2", fp_model(32'h40A8_0000, 32'h4000_0000), 32'h4128_0000);
    checkOutput("model_neg", fp_model(32'hBF80_0000, 32'h4000_0000), 32'hC000_0000);
    checkOutput("model_2p5x3p5", fp_model(32'h4020_0000, 32'h4060_0000), 32'h410C_0000);

    // Reset state.
    tick(2);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single request, 2.0 * 1.0.
    base = cap_data.size();
    applyStimulus(2'b01, 32'h4000_0000, 32'h3F80_0000, 32'd0, 32'd0, 1'b1);
    tick(1);
    applyStimulus(2'b00, 32'h4000_0000, 32'h3F80_0000, 32'd0, 32'd0, 1'b1);
    checkOutput("t1_busy_exec", {31'd0, busy}, 32'd1);
    checkOutput("t1_no_rsp_exec", {31'd0, rsp_valid}, 32'd0);
    tick(1);
    checkOutput("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("t1_rsp_data", rsp_data, 32'h4000_0000);
    tick(3);
    checkOutput("t1_rsp_count", cap_data.size() - base, 32'd1);

    // Simultaneous requests right after reset: grants 0,1,0,1.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    base = cap_data.size();
    applyStimulus(2'b11, 32'h4000_0000, 32'h4000_0000, 32'h40A8_0000, 32'h4000_0000, 1'b1);
    tick(10);
    applyStimulus(2'b00, 32'h4000_0000, 32'h4000_0000, 32'h40A8_0000, 32'h4000_0000, 1'b1);
    tick(3);
    checkOutput("t2_count", cap_data.size() - base, 32'd4);
    checkOutput("t2_r0_data", cap_at(base), 32'h4080_0000);
    checkOutput("t2_r0_id", {31'd0, cap_id_at(base)}, 32'd0);
    checkOutput("t2_r1_data", cap_at(base + 1), 32'h4128_0000);
    checkOutput("t2_r1_id", {31'd0, cap_id_at(base + 1)}, 32'd1);
    checkOutput("t2_r2_id", {31'd0, cap_id_at(base + 2)}, 32'd0);
    checkOutput("t2_r3_id", {31'd0, cap_id_at(base + 3)}, 32'd1);

    // Sign path from requester 1.
    base = cap_data.size();
    applyStimulus(2'b10, 32'd0, 32'd0, 32'hBF80_0000, 32'h4000_0000, 1'b1);
    tick(1);
    applyStimulus(2'b00, 32'd0, 32'd0, 32'hBF80_0000, 32'h4000_0000, 1'b1);
    tick(3);
    checkOutput("t3_data", cap_at(base), 32'hC000_0000);
    checkOutput("t3_id", {31'd0, cap_id_at(base)}, 32'd1);

    // Backpressure: 3.0 * 3.0 held while requester 0 stays valid.
    base = cap_data.size();
    applyStimulus(2'b01, 32'h4040_0000, 32'h4040_0000, 32'd0, 32'd0, 1'b0);
    tick(3);
    checkOutput("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("t4_hold_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("t4_hold_data", rsp_data, 32'h4110_0000);
    tick(4);
    checkOutput("t4_late_data", rsp_data, 32'h4110_0000);
    checkOutput("t4_late_id", {31'd0, rsp_id}, 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    checkOutput("t4_ready_after", {30'd0, req_ready}, 32'd1);
    tick(1);
    applyStimulus(2'b00, 32'h4040_0000, 32'h4040_0000, 32'd0, 32'd0, 1'b1);
    checkOutput("t4_second_busy", {31'd0, busy}, 32'd1);
    tick(3);
    checkOutput("t4_count", cap_data.size() - base, 32'd2);

    // Reset during EXEC aborts; next request goes to requester 0 first.
    base = cap_data.size();
    applyStimulus(2'b10, 32'd0, 32'd0, 32'h4000_0000, 32'h4040_0000, 1'b1);
    tick(1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_req_ready", {30'd0, req_ready}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    applyStimulus(2'b11, 32'h3F80_0000, 32'h40E0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    #1;
    checkOutput("t5_prio0", {30'd0, req_ready}, 32'd1);
    tick(1);
    applyStimulus(2'b00, 32'h3F80_0000, 32'h40E0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    tick(3);
    checkOutput("t5_count", cap_data.size() - base, 32'd1);
    checkOutput("t5_data", cap_at(base), 32'h40E0_0000);
    checkOutput("t5_id", {31'd0, cap_id_at(base)}, 32'd0);

    // Operand change after accept: 2.5 * 3.5 must survive a0 changing.
    base = cap_data.size();
    applyStimulus(2'b01, 32'h4020_0000, 32'h4060_0000, 32'd0, 32'd0, 1'b1);
    tick(1);
    applyStimulus(2'b00, 32'h3F80_0000, 32'h4060_0000, 32'd0, 32'd0, 1'b1);
    tick(3);
    checkOutput("t6_data", cap_at(base), 32'h410C_0000);
    checkOutput("t6_id", {31'd0, cap_id_at(base)}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
